line_fetch: RTL



---
 rtl/line_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/line_fetch.sv
// Drains a 1-cycle-latency pixel FIFO and emits one frame as a gap-free burst
// of LINES_PER_FRAME x LINE_BEATS beats, preceded by a one-cycle rd_en lead pulse.
module line_fetch #(
  parameter int DATA_WIDTH      = 128,
  parameter int LINE_BEATS      = 48,
  parameter int LINES_PER_FRAME = 1081,
  parameter int PRELOAD_BEATS   = 48,
  parameter int MIN_GAP         = 4,
  parameter int COUNT_W         = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic [COUNT_W-1:0]    fifo_rd_count,
  output logic                  rd_en,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int LINE_W = $clog2(LINES_PER_FRAME);
  localparam int AUX_W  = $clog2(MIN_GAP);

  localparam logic [BEAT_W-1:0]  BEAT_MAX = BEAT_W'(LINE_BEATS - 1);
  localparam logic [LINE_W-1:0]  LINE_MAX = LINE_W'(LINES_PER_FRAME - 1);
  localparam logic [AUX_W-1:0]   GAP_MAX  = AUX_W'(MIN_GAP - 1);
  localparam logic [AUX_W-1:0]   DRAIN_MAX = AUX_W'(1);
  localparam logic [COUNT_W:0]   PRELOAD  = (COUNT_W + 1)'(PRELOAD_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FILL,
    BURST,
    DRAIN,
    GAP
  } state_t;

  state_t              state, state_next;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic [AUX_W-1:0]    aux_cnt;
  logic                pending;
  logic                burst_first, burst_last;
  logic                issue_d1, taken_d1, last_d1;

  always_comb begin
    state_next  = state;
    fifo_rd_en  = 1'b0;
    burst_first = (state == BURST) && (beat_cnt == '0) && (line_cnt == '0);
    burst_last  = (state == BURST) && (beat_cnt == BEAT_MAX) && (line_cnt == LINE_MAX);
    case (state)
      IDLE:      if (frame_start) state_next = WAIT_FILL;
      WAIT_FILL: if ({1'b0, fifo_rd_count} >= PRELOAD) state_next = BURST;
      BURST: begin
        fifo_rd_en = !fifo_empty;
        if (burst_last) state_next = DRAIN;
      end
      DRAIN:     if (aux_cnt == DRAIN_MAX) state_next = GAP;
      GAP:       if (aux_cnt == GAP_MAX) state_next = pending ? WAIT_FILL : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // aux_cnt times both DRAIN and GAP; it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      line_cnt <= '0;
      aux_cnt  <= '0;
      pending  <= 1'b0;
    end else begin
      if (state == BURST) begin
        if (beat_cnt == BEAT_MAX) begin
          beat_cnt <= '0;
          line_cnt <= (line_cnt == LINE_MAX) ? '0 : line_cnt + LINE_W'(1);
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end else begin
        beat_cnt <= '0;
        line_cnt <= '0;
      end

      if (state_next != state)
        aux_cnt <= '0;
      else if (state == DRAIN || state == GAP)
        aux_cnt <= aux_cnt + AUX_W'(1);

      if (state_next == WAIT_FILL && state != WAIT_FILL)
        pending <= 1'b0;
      else if (frame_start && state != IDLE)
        pending <= 1'b1;
    end
  end

  // Two-stage output pipeline: stage 1 waits for the FIFO read latency,
  // stage 2 registers the beat; taken_d1 substitutes zero for skipped reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_d1   <= 1'b0;
      taken_d1   <= 1'b0;
      last_d1    <= 1'b0;
      rd_en      <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      issue_d1   <= (state == BURST);
      taken_d1   <= fifo_rd_en;
      last_d1    <= burst_last;
      rd_en      <= burst_first;
      pix_valid  <= issue_d1;
      pix_data   <= (issue_d1 && taken_d1) ? fifo_dout : '0;
      frame_done <= last_d1;
      if (issue_d1 && !taken_d1)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

endmodule
